// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the ALU/LSB buses, and issues the lowest ready slot.
// Dispatch-to-issue takes 1 cycle minimum. rs_full drops dispatch, rdy=0 freezes all state, and the ALU is never back-pressured.
module alu_rs #(
  parameter int XLEN    = 32,
  parameter int OP_W    = 4,
  parameter int TAG_W   = 3,
  parameter int RS_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             dec_valid,
  input  logic [OP_W-1:0]  dec_op,
  input  logic [TAG_W-1:0] dec_id,
  input  logic [XLEN-1:0]  dec_val1,
  input  logic             dec_has_q1,
  input  logic [TAG_W-1:0] dec_q1,
  input  logic [XLEN-1:0]  dec_val2,
  input  logic             dec_has_q2,
  input  logic [TAG_W-1:0] dec_q2,
  output logic             rs_full,
  input  logic             alu_ready,
  input  logic [XLEN-1:0]  alu_res,
  input  logic [TAG_W-1:0] alu_id,
  input  logic             lsb_ready,
  input  logic [XLEN-1:0]  lsb_res,
  input  logic [TAG_W-1:0] lsb_id,
  output logic             rs_ready,
  output logic [OP_W-1:0]  rs_op,
  output logic [XLEN-1:0]  rs_val1,
  output logic [XLEN-1:0]  rs_val2,
  output logic [TAG_W-1:0] rs_id
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] id;
    logic [XLEN-1:0]  val1;
    logic             has_q1;
    logic [TAG_W-1:0] q1;
    logic [XLEN-1:0]  val2;
    logic             has_q2;
    logic [TAG_W-1:0] q2;
  } ent_t;

  ent_t ent_q [RS_SIZE];
  ent_t ent_d [RS_SIZE];

  logic             iss_vld;
  logic [IDX_W-1:0] iss_idx;
  logic [IDX_W-1:0] free_idx;
  logic             full;

  logic             rs_ready_q, rs_ready_d;
  logic [OP_W-1:0]  rs_op_q, rs_op_d;
  logic [XLEN-1:0]  rs_val1_q, rs_val1_d;
  logic [XLEN-1:0]  rs_val2_q, rs_val2_d;
  logic [TAG_W-1:0] rs_id_q, rs_id_d;

  // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [XLEN:0] snoop(input logic has_q, input logic [TAG_W-1:0] q,
                                          input logic [XLEN-1:0] val);
    snoop = {has_q, val};
    if (has_q) begin
      if (alu_ready && alu_id == q)      snoop = {1'b0, alu_res};
      else if (lsb_ready && lsb_id == q) snoop = {1'b0, lsb_res};
    end
  endfunction

  // Downward scan so the lowest index is the last one to be written.
  always_comb begin
    iss_vld  = 1'b0;
    iss_idx  = '0;
    full     = 1'b1;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ent_q[i].busy && !ent_q[i].has_q1 && !ent_q[i].has_q2) begin
        iss_vld = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!ent_q[i].busy) begin
        full     = 1'b0;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign rs_full = full;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        {ent_d[i].has_q1, ent_d[i].val1} = snoop(ent_q[i].has_q1, ent_q[i].q1, ent_q[i].val1);
        {ent_d[i].has_q2, ent_d[i].val2} = snoop(ent_q[i].has_q2, ent_q[i].q2, ent_q[i].val2);
      end
    end
    if (iss_vld) ent_d[iss_idx].busy = 1'b0;
    // free_idx is never busy, so it can never be the slot issuing this cycle.
    if (dec_valid && !full) begin
      ent_d[free_idx].busy = 1'b1;
      ent_d[free_idx].op   = dec_op;
      ent_d[free_idx].id   = dec_id;
      ent_d[free_idx].q1   = dec_q1;
      ent_d[free_idx].q2   = dec_q2;
      {ent_d[free_idx].has_q1, ent_d[free_idx].val1} = snoop(dec_has_q1, dec_q1, dec_val1);
      {ent_d[free_idx].has_q2, ent_d[free_idx].val2} = snoop(dec_has_q2, dec_q2, dec_val2);
    end
    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
    end
  end

  always_comb begin
    rs_ready_d = iss_vld && !flush;
    rs_op_d    = rs_op_q;
    rs_val1_d  = rs_val1_q;
    rs_val2_d  = rs_val2_q;
    rs_id_d    = rs_id_q;
    if (rs_ready_d) begin
      rs_op_d   = ent_q[iss_idx].op;
      rs_val1_d = ent_q[iss_idx].val1;
      rs_val2_d = ent_q[iss_idx].val2;
      rs_id_d   = ent_q[iss_idx].id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      rs_ready_q <= 1'b0;
      rs_op_q    <= '0;
      rs_val1_q  <= '0;
      rs_val2_q  <= '0;
      rs_id_q    <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      rs_ready_q <= rs_ready_d;
      rs_op_q    <= rs_op_d;
      rs_val1_q  <= rs_val1_d;
      rs_val2_q  <= rs_val2_d;
      rs_id_q    <= rs_id_d;
    end
  end

  assign rs_ready = rs_ready_q;
  assign rs_op    = rs_op_q;
  assign rs_val1  = rs_val1_q;
  assign rs_val2  = rs_val2_q;
  assign rs_id    = rs_id_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: a vector table, directed multi-cycle sequences, then random traffic against a slot-array model.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, dec_valid;
  logic [3:0]  dec_op;
  logic [2:0]  dec_id, dec_q1, dec_q2;
  logic [31:0] dec_val1, dec_val2;
  logic        dec_has_q1, dec_has_q2;
  logic        rs_full;
  logic        alu_ready, lsb_ready;
  logic [31:0] alu_res, lsb_res;
  logic [2:0]  alu_id, lsb_id;
  logic        rs_ready;
  logic [3:0]  rs_op;
  logic [31:0] rs_val1, rs_val2;
  logic [2:0]  rs_id;

  int tests = 0;
  int fails = 0;

  alu_rs #(.XLEN(32), .OP_W(4), .TAG_W(3), .RS_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_id(dec_id),
    .dec_val1(dec_val1), .dec_has_q1(dec_has_q1), .dec_q1(dec_q1),
    .dec_val2(dec_val2), .dec_has_q2(dec_has_q2), .dec_q2(dec_q2),
    .rs_full(rs_full),
    .alu_ready(alu_ready), .alu_res(alu_res), .alu_id(alu_id),
    .lsb_ready(lsb_ready), .lsb_res(lsb_res), .lsb_id(lsb_id),
    .rs_ready(rs_ready), .rs_op(rs_op), .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic r, input logic [3:0] op, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [2:0] id, input logic full);
    chk({nm, ".rs_ready"}, 32'(rs_ready), 32'(r));
    chk({nm, ".rs_op"},    32'(rs_op),    32'(op));
    chk({nm, ".rs_val1"},  rs_val1,       v1);
    chk({nm, ".rs_val2"},  rs_val2,       v2);
    chk({nm, ".rs_id"},    32'(rs_id),    32'(id));
    chk({nm, ".rs_full"},  32'(rs_full),  32'(full));
  endtask

  task automatic set_idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; dec_valid = 1'b0;
    dec_op = '0; dec_id = '0; dec_val1 = '0; dec_has_q1 = 1'b0; dec_q1 = '0;
    dec_val2 = '0; dec_has_q2 = 1'b0; dec_q2 = '0;
    alu_ready = 1'b0; alu_res = '0; alu_id = '0;
    lsb_ready = 1'b0; lsb_res = '0; lsb_id = '0;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [2:0] id,
                          input logic [31:0] v1, input logic h1, input logic [2:0] q1,
                          input logic [31:0] v2, input logic h2, input logic [2:0] q2);
    dec_valid = 1'b1; dec_op = op; dec_id = id;
    dec_val1 = v1; dec_has_q1 = h1; dec_q1 = q1;
    dec_val2 = v2; dec_has_q2 = h2; dec_q2 = q2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        dv;  logic [3:0] op; logic [2:0] id;
    logic [31:0] v1;  logic h1;       logic [2:0] q1;
    logic [31:0] v2;  logic h2;       logic [2:0] q2;
    logic        ar;  logic [31:0] ares; logic [2:0] aid;
    logic        lr;  logic [31:0] lres; logic [2:0] lid;
    logic        e_rdy; logic [3:0] e_op; logic [31:0] e_v1; logic [31:0] e_v2;
    logic [2:0]  e_id;  logic e_full;
  } vec_t;

  vec_t vecs [19];

  // ---------------- reference model: slot array driven by the stated rules ----------------
  logic        m_busy [8];
  logic [3:0]  m_op   [8];
  logic [2:0]  m_id   [8];
  logic [31:0] m_v1   [8];
  logic [31:0] m_v2   [8];
  logic        m_h1   [8];
  logic        m_h2   [8];
  logic [2:0]  m_q1   [8];
  logic [2:0]  m_q2   [8];
  logic        m_rdy;
  logic [3:0]  m_oop;
  logic [31:0] m_ov1, m_ov2;
  logic [2:0]  m_oid;

  function automatic logic [32:0] grab(input logic has, input logic [2:0] q, input logic [31:0] v);
    if (!has) return {1'b0, v};
    if (alu_ready && alu_id == q) return {1'b0, alu_res};
    if (lsb_ready && lsb_id == q) return {1'b0, lsb_res};
    return {1'b1, v};
  endfunction

  function automatic logic m_full();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_busy[i]) n++;
    return n == 8;
  endfunction

  task automatic model_step();
    int win = -1;
    int fr = -1;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_rdy = 1'b0; m_oop = '0; m_ov1 = '0; m_ov2 = '0; m_oid = '0;
      return;
    end
    if (!rdy) return;
    for (int i = 0; i < 8; i++) begin
      if (win < 0 && m_busy[i] && !m_h1[i] && !m_h2[i]) win = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_busy[i]) begin
        {m_h1[i], m_v1[i]} = grab(m_h1[i], m_q1[i], m_v1[i]);
        {m_h2[i], m_v2[i]} = grab(m_h2[i], m_q2[i], m_v2[i]);
      end
    end
    m_rdy = 1'b0;
    if (win >= 0) begin
      m_rdy = 1'b1;
      m_oop = m_op[win]; m_ov1 = m_v1[win]; m_ov2 = m_v2[win]; m_oid = m_id[win];
      m_busy[win] = 1'b0;
    end
    if (dec_valid && fr >= 0) begin
      m_busy[fr] = 1'b1; m_op[fr] = dec_op; m_id[fr] = dec_id;
      m_q1[fr] = dec_q1; m_q2[fr] = dec_q2;
      {m_h1[fr], m_v1[fr]} = grab(dec_has_q1, dec_q1, dec_val1);
      {m_h2[fr], m_v2[fr]} = grab(dec_has_q2, dec_q2, dec_val2);
    end
    if (flush) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_rdy = 1'b0;
    end
  endtask

  initial begin
    //        dv op  id  v1            h1 q1  v2            h2 q2  ar ares        aid  lr lres          lid  rdy op  v1            v2            id  full
    vecs[0]  = '{1, 0, 2, 32'd5,        0, 0, 32'd7,        0, 0,  0, 0,          0,   0, 0,            0,   0, 0, 32'd0,        32'd0,        0, 0};
    vecs[1]  = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   1, 0, 32'd5,        32'd7,        2, 0};
    vecs[2]  = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   0, 0, 32'd5,        32'd7,        2, 0};
    vecs[3]  = '{1, 1, 3, 32'hDEAD,     1, 1, 32'd4,        0, 0,  0, 0,          0,   0, 0,            0,   0, 0, 32'd5,        32'd7,        2, 0};
    vecs[4]  = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   0, 0, 32'd5,        32'd7,        2, 0};
    vecs[5]  = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  1, 32'h10,     1,   0, 0,            0,   0, 0, 32'd5,        32'd7,        2, 0};
    vecs[6]  = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   1, 1, 32'h10,       32'd4,        3, 0};
    vecs[7]  = '{1, 2, 4, 32'd9,        0, 0, 32'h55,       1, 5,  0, 0,          0,   1, 32'hFFFFFFFF, 5,   0, 1, 32'h10,       32'd4,        3, 0};
    vecs[8]  = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   1, 2, 32'd9,        32'hFFFFFFFF, 4, 0};
    vecs[9]  = '{1, 3, 5, 32'd1,        1, 6, 32'd2,        1, 6,  1, 32'hA,      6,   1, 32'hB,        6,   0, 2, 32'd9,        32'hFFFFFFFF, 4, 0};
    vecs[10] = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   1, 3, 32'hA,        32'hA,        5, 0};
    vecs[11] = '{1, 4, 6, 32'd0,        1, 2, 32'd0,        1, 3,  0, 0,          0,   0, 0,            0,   0, 3, 32'hA,        32'hA,        5, 0};
    vecs[12] = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  1, 32'h22,     2,   1, 32'h33,       3,   0, 3, 32'hA,        32'hA,        5, 0};
    vecs[13] = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   1, 4, 32'h22,       32'h33,       6, 0};
    vecs[14] = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   0, 4, 32'h22,       32'h33,       6, 0};
    vecs[15] = '{1, 5, 7, 32'd1,        0, 0, 32'd2,        0, 0,  0, 0,          0,   0, 0,            0,   0, 4, 32'h22,       32'h33,       6, 0};
    vecs[16] = '{1, 6, 0, 32'd3,        0, 0, 32'd4,        0, 0,  0, 0,          0,   0, 0,            0,   1, 5, 32'd1,        32'd2,        7, 0};
    vecs[17] = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   1, 6, 32'd3,        32'd4,        0, 0};
    vecs[18] = '{0, 0, 0, 32'd0,        0, 0, 32'd0,        0, 0,  0, 0,          0,   0, 0,            0,   0, 6, 32'd3,        32'd4,        0, 0};

    // Reset must win even while rdy is low.
    set_idle();
    rst = 1'b1; rdy = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 4'd0, 32'd0, 32'd0, 3'd0, 1'b0);
    set_idle();

    for (int i = 0; i < 19; i++) begin
      set_idle();
      if (vecs[i].dv)
        dispatch(vecs[i].op, vecs[i].id, vecs[i].v1, vecs[i].h1, vecs[i].q1,
                 vecs[i].v2, vecs[i].h2, vecs[i].q2);
      alu_ready = vecs[i].ar; alu_res = vecs[i].ares; alu_id = vecs[i].aid;
      lsb_ready = vecs[i].lr; lsb_res = vecs[i].lres; lsb_id = vecs[i].lid;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_op, vecs[i].e_v1,
              vecs[i].e_v2, vecs[i].e_id, vecs[i].e_full);
    end

    // Fill all slots waiting on tag 7, overflow, then drain in slot order.
    for (int i = 0; i < 8; i++) begin
      set_idle();
      dispatch(4'(i), 3'(i), 32'd0, 1'b1, 3'd7, 32'(100 + i), 1'b0, 3'd0);
      tick();
      chk($sformatf("fill%0d.rs_ready", i), 32'(rs_ready), 32'd0);
      chk($sformatf("fill%0d.rs_full", i), 32'(rs_full), 32'(i == 7));
    end
    set_idle();
    dispatch(4'd15, 3'd0, 32'hBAD, 1'b0, 3'd0, 32'hBAD, 1'b0, 3'd0);
    tick();
    chk("overflow.rs_full", 32'(rs_full), 32'd1);
    chk("overflow.rs_ready", 32'(rs_ready), 32'd0);
    set_idle();
    alu_ready = 1'b1; alu_res = 32'h77; alu_id = 3'd7;
    tick();
    chk("wake7.rs_ready", 32'(rs_ready), 32'd0);
    set_idle();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out($sformatf("drain%0d", k), 1'b1, 4'(k), 32'h77, 32'(100 + k), 3'(k), 1'b0);
    end
    tick();
    chk("drain_end.rs_ready", 32'(rs_ready), 32'd0);

    // Flush with three ready entries and a same-cycle dispatch.
    for (int i = 1; i <= 3; i++) begin
      set_idle();
      dispatch(4'd1, 3'(i), 32'd0, 1'b1, 3'd6, 32'd0, 1'b0, 3'd0);
      tick();
    end
    set_idle();
    alu_ready = 1'b1; alu_res = 32'h66; alu_id = 3'd6;
    tick();
    chk("preflush.rs_ready", 32'(rs_ready), 32'd0);
    set_idle();
    flush = 1'b1;
    dispatch(4'd9, 3'd5, 32'd1, 1'b0, 3'd0, 32'd2, 1'b0, 3'd0);
    tick();
    chk("flush.rs_ready", 32'(rs_ready), 32'd0);
    chk("flush.rs_full", 32'(rs_full), 32'd0);
    set_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("postflush%0d.rs_ready", i), 32'(rs_ready), 32'd0);
    end

    // Stall with rdy=0 while an issue is showing and a matching broadcast is present.
    set_idle();
    dispatch(4'd2, 3'd1, 32'h11, 1'b0, 3'd0, 32'h12, 1'b0, 3'd0);
    tick();
    set_idle();
    dispatch(4'd3, 3'd3, 32'd0, 1'b1, 3'd4, 32'h32, 1'b0, 3'd0);
    tick();
    chk_out("stall_pre", 1'b1, 4'd2, 32'h11, 32'h12, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_idle();
      rdy = 1'b0;
      dispatch(4'd7, 3'd5, 32'h5, 1'b0, 3'd0, 32'h5, 1'b0, 3'd0);
      alu_ready = 1'b1; alu_res = 32'h44; alu_id = 3'd4;
      tick();
      chk_out($sformatf("stall%0d", i), 1'b1, 4'd2, 32'h11, 32'h12, 3'd1, 1'b0);
    end
    set_idle();
    tick();
    chk_out("resume0", 1'b0, 4'd2, 32'h11, 32'h12, 3'd1, 1'b0);
    alu_ready = 1'b1; alu_res = 32'h44; alu_id = 3'd4;
    tick();
    chk("resume1.rs_ready", 32'(rs_ready), 32'd0);
    set_idle();
    tick();
    chk_out("resume2", 1'b1, 4'd3, 32'h44, 32'h32, 3'd3, 1'b0);
    tick();
    chk("resume3.rs_ready", 32'(rs_ready), 32'd0);

    // Random traffic against the model.
    set_idle();
    rst = 1'b1;
    model_step();
    tick();
    for (int c = 0; c < 3000; c++) begin
      bit burst = ((c / 200) % 2) == 0;
      rst        = ($urandom_range(0, 299) == 0);
      rdy        = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      dec_valid  = burst ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
      dec_op     = 4'($urandom);
      dec_id     = 3'($urandom);
      dec_val1   = $urandom;
      dec_val2   = $urandom;
      dec_has_q1 = burst ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 2) == 0);
      dec_has_q2 = burst ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 2) == 0);
      dec_q1     = 3'($urandom);
      dec_q2     = 3'($urandom);
      alu_ready  = burst ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      alu_res    = $urandom;
      alu_id     = 3'($urandom);
      lsb_ready  = burst ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      lsb_res    = $urandom;
      lsb_id     = 3'($urandom);
      model_step();
      tick();
      chk($sformatf("rnd%0d.rs_ready", c), 32'(rs_ready), 32'(m_rdy));
      chk($sformatf("rnd%0d.rs_full", c), 32'(rs_full), 32'(m_full()));
      if (m_rdy) begin
        chk($sformatf("rnd%0d.rs_op", c), 32'(rs_op), 32'(m_oop));
        chk($sformatf("rnd%0d.rs_val1", c), rs_val1, m_ov1);
        chk($sformatf("rnd%0d.rs_val2", c), rs_val2, m_ov2);
        chk($sformatf("rnd%0d.rs_id", c), 32'(rs_id), 32'(m_oid));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
